// File: rtl/grid_line_clear.sv
// Tetris row-clear engine driving Grid_Mem port A: removes full rows bottom-to-top and reports the count.
// Optional LINE_CLEAR_SCORE_EN adds a saturating score accumulator with synchronous clear.
module grid_line_clear #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int AW   = 8,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [4:0]    lines_cleared,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
`ifdef LINE_CLEAR_SCORE_EN
  ,
  input  logic          score_clr,
  output logic [15:0]   score
`endif
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, SCAN_CHK, SHIFT_RD, SHIFT_WR, CLEAR_TOP, DONE
  } state_t;

  state_t        state_reg;
  logic [RW-1:0] row_reg;
  logic [RW-1:0] shift_row_reg;
  logic [CW-1:0] col_reg;
  logic          full_reg;
  logic          fwd_reg;
  logic          cell_nz;

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(int'(r) * COLS + int'(c));
  endfunction

  assign cell_nz = (mem_rdata != '0);

  // Shift writes forward the sync-read result straight to the write port so a cell moves in
  // two cycles; the select is registered, so wdata is zero whenever no copy is in flight.
  assign mem_wdata = fwd_reg ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      shift_row_reg <= '0;
      col_reg       <= '0;
      full_reg      <= 1'b0;
      fwd_reg       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            row_reg       <= ROW_LAST;
            col_reg       <= '0;
            lines_cleared <= '0;
            busy          <= 1'b1;
            mem_addr      <= cell_addr(ROW_LAST, '0);
            state_reg     <= SCAN;
          end
        end

        SCAN: begin
          // Data for the previous column arrives now; column 0 restarts the AND chain.
          full_reg <= (col_reg == '0) ? 1'b1 : (full_reg & cell_nz);
          if (col_reg == COL_LAST) begin
            state_reg <= SCAN_CHK;
          end else begin
            col_reg  <= col_reg + CW'(1);
            mem_addr <= cell_addr(row_reg, col_reg + CW'(1));
          end
        end

        SCAN_CHK: begin
          col_reg <= '0;
          if (full_reg && cell_nz) begin
            if (lines_cleared != 5'h1F) lines_cleared <= lines_cleared + 5'd1;
            if (row_reg == '0) begin
              mem_addr  <= cell_addr('0, '0);
              mem_we    <= 1'b1;
              state_reg <= CLEAR_TOP;
            end else begin
              shift_row_reg <= row_reg;
              mem_addr      <= cell_addr(row_reg - RW'(1), '0);
              state_reg     <= SHIFT_RD;
            end
          end else if (row_reg == '0) begin
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            row_reg   <= row_reg - RW'(1);
            mem_addr  <= cell_addr(row_reg - RW'(1), '0);
            state_reg <= SCAN;
          end
        end

        SHIFT_RD: begin
          mem_addr  <= cell_addr(shift_row_reg, col_reg);
          mem_we    <= 1'b1;
          fwd_reg   <= 1'b1;
          state_reg <= SHIFT_WR;
        end

        SHIFT_WR: begin
          mem_we  <= 1'b0;
          fwd_reg <= 1'b0;
          if (col_reg == COL_LAST) begin
            col_reg <= '0;
            if (shift_row_reg == RW'(1)) begin
              mem_addr  <= cell_addr('0, '0);
              mem_we    <= 1'b1;
              state_reg <= CLEAR_TOP;
            end else begin
              shift_row_reg <= shift_row_reg - RW'(1);
              mem_addr      <= cell_addr(shift_row_reg - RW'(2), '0);
              state_reg     <= SHIFT_RD;
            end
          end else begin
            col_reg   <= col_reg + CW'(1);
            mem_addr  <= cell_addr(shift_row_reg - RW'(1), col_reg + CW'(1));
            state_reg <= SHIFT_RD;
          end
        end

        CLEAR_TOP: begin
          if (col_reg == COL_LAST) begin
            // Rescan the same row: it now holds what was shifted down into it.
            mem_we    <= 1'b0;
            col_reg   <= '0;
            mem_addr  <= cell_addr(row_reg, '0);
            state_reg <= SCAN;
          end else begin
            col_reg  <= col_reg + CW'(1);
            mem_addr <= cell_addr('0, col_reg + CW'(1));
          end
        end

        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_add;
  logic [16:0] score_sum;

  always_comb begin
    score_add = 16'd0;
    case (lines_cleared)
      5'd0:    score_add = 16'd0;
      5'd1:    score_add = 16'd40;
      5'd2:    score_add = 16'd100;
      5'd3:    score_add = 16'd300;
      default: score_add = 16'd1200;
    endcase
    score_sum = {1'b0, score} + {1'b0, score_add};
  end

  always_ff @(posedge clk) begin
    if (reset || score_clr) begin
      score <= '0;
    end else if (state_reg == DONE) begin
      score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_grid_line_clear.sv
// Self-checking bench for grid_line_clear: behavioural Grid_Mem, reference row-clear model,
// and a scoreboard of expected results popped when done pulses.
module tb_grid_line_clear;
  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int CELLS = COLS * ROWS;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [4:0]    lines_cleared;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
`ifdef LINE_CLEAR_SCORE_EN
  logic          score_clr;
  logic [15:0]   score;
`endif

  always #5 clk = ~clk;

  grid_line_clear #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata)
`ifdef LINE_CLEAR_SCORE_EN
    ,
    .score_clr     (score_clr),
    .score         (score)
`endif
  );

  // Grid memory: sync read with old-data-on-write; a bench load port preloads the grid while idle.
  logic [DW-1:0] mem [0:255];
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  int            we_count = 0;

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
    if (mem_we) we_count <= we_count + 1;
  end

  typedef struct {
    string tag;
    int    lines;
    int    writes;
    int    cycles;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] init_grid [CELLS];
  logic [7:0] exp_grid  [CELLS];
  int         tests = 0;
  int         fails = 0;
  int         last_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_init();
    for (int i = 0; i < CELLS; i++) init_grid[i] = 8'h00;
  endtask

  task automatic set_row(input int r, input logic [7:0] v);
    for (int c = 0; c < COLS; c++) init_grid[r*COLS + c] = v;
  endtask

  task automatic load_grid();
    for (int i = 0; i < CELLS; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = init_grid[i];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Reference: repeatedly scan from the bottom, collapse full rows, rescan the same row.
  task automatic model(input string tag);
    exp_t e;
    int   r = ROWS - 1;
    bit   full;
    e.tag = tag; e.lines = 0; e.writes = 0; e.cycles = 1;
    for (int i = 0; i < CELLS; i++) exp_grid[i] = init_grid[i];
    while (1) begin
      e.cycles += COLS + 1;
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (exp_grid[r*COLS + c] == 8'h00) full = 1'b0;
      if (full) begin
        e.lines++;
        for (int rr = r; rr > 0; rr--)
          for (int c = 0; c < COLS; c++) exp_grid[rr*COLS + c] = exp_grid[(rr-1)*COLS + c];
        for (int c = 0; c < COLS; c++) exp_grid[c] = 8'h00;
        e.writes += (r + 1) * COLS;
        e.cycles += 2 * COLS * r + COLS;
      end else if (r == 0) begin
        break;
      end else begin
        r--;
      end
    end
    sb.push_back(e);
  endtask

  task automatic run_op(input string tag, input bit poke_busy);
    exp_t e;
    int   cyc;
    int   w0;
    int   bad_idx;
    int   extra_done;
    model(tag);
    @(negedge clk);
    start = 1'b1;
    w0 = we_count;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (poke_busy && cyc == 6) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    e = sb.pop_front();
    last_cycles = cyc;
    check({e.tag, "_done_seen"}, 32'(done), 32'd1);
    check({e.tag, "_busy_in_done"}, 32'(busy), 32'd1);
    check({e.tag, "_lines"}, 32'(lines_cleared), 32'(e.lines));
    check({e.tag, "_cycles"}, 32'(cyc), 32'(e.cycles));
    check({e.tag, "_writes"}, 32'(we_count - w0), 32'(e.writes));
    bad_idx = -1;
    for (int i = CELLS - 1; i >= 0; i--) if (mem[i] !== exp_grid[i]) bad_idx = i;
    check({e.tag, "_grid_first_bad_addr"}, 32'(bad_idx), 32'hFFFF_FFFF);
    $display("[TB] op %s: lines=%0d cycles=%0d writes=%0d", e.tag, lines_cleared, cyc, we_count - w0);
    @(posedge clk);
    #1;
    check({e.tag, "_done_pulse_end"}, 32'(done), 32'd0);
    check({e.tag, "_busy_fall"}, 32'(busy), 32'd0);
    if (poke_busy) begin
      extra_done = 0;
      repeat (300) begin
        @(posedge clk);
        #1;
        if (done === 1'b1 || busy === 1'b1) extra_done++;
      end
      check({e.tag, "_no_second_op"}, 32'(extra_done), 32'd0);
    end
  endtask

  initial begin
    int found;
    reset = 1'b1;
    start = 1'b0;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
`ifdef LINE_CLEAR_SCORE_EN
    score_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
`ifdef LINE_CLEAR_SCORE_EN
    check("rst_score", 32'(score), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Empty grid: full scan, no writes.
    clear_init();
    load_grid();
    run_op("empty", 1'b0);
    check("empty_cycles_221", 32'(last_cycles), 32'd221);

    // Bottom row full, one cell above it.
    clear_init();
    set_row(19, 8'h01);
    init_grid[18*COLS + 0] = 8'h05;
    load_grid();
    run_op("one_line", 1'b0);
    check("one_line_addr190", 32'(mem[190]), 32'h05);
    check("one_line_addr191", 32'(mem[191]), 32'h00);

    // Four stacked full rows.
`ifdef LINE_CLEAR_SCORE_EN
    @(negedge clk);
    score_clr = 1'b1;
    @(negedge clk);
    score_clr = 1'b0;
`endif
    clear_init();
    set_row(16, 8'h11);
    set_row(17, 8'h22);
    set_row(18, 8'h33);
    set_row(19, 8'h44);
    init_grid[15*COLS + 3] = 8'h07;
    load_grid();
    run_op("four_lines", 1'b0);
    check("four_lines_addr193", 32'(mem[193]), 32'h07);
`ifdef LINE_CLEAR_SCORE_EN
    check("four_lines_score", 32'(score), 32'd1200);
`endif

    // Only the top row full.
    clear_init();
    set_row(0, 8'h09);
    load_grid();
    run_op("top_row", 1'b0);

    // Last column empty: catches a missing late compare.
    clear_init();
    set_row(19, 8'h03);
    init_grid[19*COLS + 9] = 8'h00;
    load_grid();
    run_op("late_cmp", 1'b0);

    // Random grid with several full rows, plus a start pulse while busy.
    clear_init();
    for (int i = 0; i < CELLS; i++)
      init_grid[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    set_row(3, 8'hA5);
    set_row(10, 8'h5A);
    set_row(11, 8'h3C);
    set_row(19, 8'hC3);
    load_grid();
    run_op("random_poke", 1'b1);

    // Reset during the first shift write.
    clear_init();
    set_row(19, 8'h22);
    init_grid[5*COLS + 2] = 8'h44;
    load_grid();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (mem_we === 1'b1) found = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("midrst_saw_shift_we", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_lines", 32'(lines_cleared), 32'd0);
    $display("[TB] op midrst: reset applied during shift write");
    @(negedge clk);
    reset = 1'b0;

    // Recovery after reset: two separated full rows.
    clear_init();
    set_row(7, 8'h0F);
    set_row(14, 8'hF0);
    init_grid[6*COLS + 4] = 8'h66;
    load_grid();
    run_op("after_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
